mux_arbiter: RTL
================

Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one Mux datapath (CHANNELS x WIDTH) between CHANNELS requesters.
- Each requester presents a packet as valid/last beats. The arbiter grants one channel at a time and holds the grant until that channel's last beat or a MAX_HOLD beat limit.
- It drives the Mux sel/enable and returns per-channel ready.
- It sits between requester FIFOs and a single downstream consumer with valid/ready.

Parameters:
- CHANNELS, 4, number of requesters (>=2; need not be a power of two).
- WIDTH, 8, data width per channel.
- ADDR_SIZE, $clog2(CHANNELS), width of sel (derived, not overridden).
- MAX_HOLD, 16, maximum beats per grant before forced release (>=1).

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  CHANNELS  per-channel beat valid.
- last  input  CHANNELS  per-channel final-beat flag, qualified by req.
- in  input  WIDTH*CHANNELS  channel data, channel i at [WIDTH*i +: WIDTH].
- ready  output  CHANNELS  per-channel beat accept.
- out_data  output  WIDTH  muxed data.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accept.
- sel  output  ADDR_SIZE  registered Mux select.
- enable  output  1  registered Mux enable.
- busy  output  1  grant active.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low on reset_n.
- Reset values:
  - state=IDLE, sel=0, enable=0, busy=0.
  - beat count=0, rr pointer=CHANNELS-1, so channel 0 wins first.
  - ready=0, out_valid=0, out_data=0.
- IDLE state:
  - If any req bit is set, select the first set bit scanning ptr+1, ptr+2, ... modulo CHANNELS.
  - Register sel=winner, enable=1, busy=1; next state GRANT.
  - Arbitration latency: 1 cycle from req to grant.
  - No req set: stay in IDLE.
- GRANT state:
  - out_valid = req[sel]; out_data = in[sel] (zero when enable=0); ready[sel] = out_ready.
  - All other ready bits are 0.
  - A beat transfers when req[sel] && out_ready; each transfer increments the beat count.
  - Release when a transfer has last[sel]=1, or when it is the MAX_HOLD-th beat.
  - On release: ptr<=sel, count<=0, enable<=0, busy<=0; next state IDLE. This leaves one bubble cycle between grants.
  - sel keeps its value after release (only enable drops).
- Held grant:
  - If req[sel] deasserts mid-packet, the grant is held, out_valid=0, and the count is unchanged. There is no timeout.
- Fairness:
  - A channel released by MAX_HOLD becomes lowest priority.
  - It resumes its packet on its next grant; the arbiter does not track packet state.
- Other requesters:
  - Non-selected req/last are ignored during GRANT.
  - Changes to req bits other than sel do not affect the current grant.
- Range:
  - sel never exceeds CHANNELS-1. The pointer wraps from CHANNELS-1 to 0.
- Reset mid-packet:
  - Immediate return to reset values.
  - ready deasserts asynchronously with reset_n low.
- Combinational paths:
  - out_ready -> ready[sel].
  - req -> out_valid.
  - in -> out_data, through the Mux.

Decomposition:
- Package mux_arbiter_pkg:
  - typedef enum {IDLE, GRANT} arb_state_t.
  - function next_ptr for modulo increment.
- Sub-module rr_pick (combinational):
  - Inputs: req, ptr. Outputs: winner index, any.
  - Rotate-mask priority encoder, parameterised by CHANNELS.
- Datapath:
  - Instantiates the existing Mux #(CHANNELS, WIDTH) with sel/enable.
  - The existing Decoder drives the ready one-hot, gated by out_ready.

Test Plan:
- Reset, then req=4'b0101, all last=1, out_ready=1: grant ch0 next cycle with 1 beat; bubble; grant ch2; then ch0 again. Order 0,2,0,2.
- Ch1 sends 3 beats (last on 3rd) while ch3 requests: ch1 data appears on out_data for 3 cycles with ready[1]=1; ch3 is granted 2 cycles after ch1's last beat.
- MAX_HOLD=16, ch0 streams 20 beats with no last, ch2 waiting: release after beat 16; ch2 served next; ch0 resumes beat 17 on its following grant.
- out_ready held 0 for 5 cycles during a grant: ready all 0; count, sel and data stable; transfer completes on the first cycle out_ready=1.
- reset_n pulled low mid-packet (beat 2 of 4): enable, busy, ready all 0 immediately; after release the first grant goes to the lowest requesting channel from 0.
- CHANNELS=3, all requesting continuously: grant sequence 0,1,2,0,1,2; sel never 3.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg
// Shared types and helpers for the round-robin mux arbiter.
//   arb_state_t : arbiter FSM states (IDLE waits for requests, GRANT owns the datapath)
//   next_ptr    : modulo-CHANNELS increment of a channel index
package mux_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Step a channel index by one, wrapping from channels-1 back to 0.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned channels);
        int unsigned res;
        if (ptr >= channels - 32'd1) begin
            res = 32'd0;
        end else begin
            res = ptr + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder.sv
// decoder
// Binary-to-one-hot decoder with enable.
//   sel    [ADDR_SIZE] : index to decode
//   enable             : all outputs zero when low
//   onehot [CHANNELS]  : one-hot of sel
module decoder #(
    parameter int CHANNELS  = 4,
    parameter int ADDR_SIZE = 2
) (
    input  logic [ADDR_SIZE-1:0] sel,
    input  logic                 enable,
    output logic [CHANNELS-1:0]  onehot
);

    // Decode sel into a single active bit.
    always_comb begin
        onehot = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable && (sel == ADDR_SIZE'(i))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux.sv
// mux
// CHANNELS-to-1 data multiplexer with enable. Output is forced to zero when
// enable is low so that no stale channel data leaks downstream.
//   sel    [ADDR_SIZE]        : channel select
//   enable                    : output enable
//   in     [WIDTH*CHANNELS]   : channel i at [WIDTH*i +: WIDTH]
//   out    [WIDTH]            : selected data or zero
module mux #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int ADDR_SIZE = 2
) (
    input  logic [ADDR_SIZE-1:0]      sel,
    input  logic                      enable,
    input  logic [WIDTH*CHANNELS-1:0] in,
    output logic [WIDTH-1:0]          out
);

    // Select one channel slice, zero when disabled or sel out of range.
    always_comb begin
        out = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (enable && (sel == ADDR_SIZE'(i))) begin
                out = in[WIDTH*i +: WIDTH];
            end else begin
                out = out;
            end
        end
    end

endmodule

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. The request vector is rotated so that the
// channel just after ptr lands at bit 0; the lowest set bit of the rotated
// vector is the winner, mapped back to an absolute channel index.
//   req    [CHANNELS]  : per-channel request
//   ptr    [ADDR_SIZE] : most recently served channel (lowest priority)
//   winner [ADDR_SIZE] : selected channel, valid when any=1
//   any                : at least one request present
module rr_pick
    import mux_arbiter_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int ADDR_SIZE = 2
) (
    input  logic [CHANNELS-1:0]  req,
    input  logic [ADDR_SIZE-1:0] ptr,
    output logic [ADDR_SIZE-1:0] winner,
    output logic                 any
);

    int unsigned         start_s;
    int unsigned         hit_s;
    int unsigned         idx_s;
    logic [CHANNELS-1:0] rot_s;

    // Rotate-mask priority encode starting one past ptr.
    always_comb begin
        start_s = next_ptr(32'(ptr), 32'(CHANNELS));
        // Doubling the vector turns the rotate into a plain right shift.
        rot_s   = CHANNELS'({req, req} >> start_s);
        any     = |rot_s;
        hit_s   = 32'd0;
        // Walk downward so the lowest set bit is the last one written.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                hit_s = 32'(k);
            end else begin
                hit_s = hit_s;
            end
        end
        idx_s = start_s + hit_s;
        if (idx_s >= 32'(CHANNELS)) begin
            idx_s = idx_s - 32'(CHANNELS);
        end else begin
            idx_s = idx_s;
        end
        winner = ADDR_SIZE'(idx_s);
    end

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter
// Round-robin arbiter sharing one mux datapath between CHANNELS packet
// requesters. A grant is held until the owner's last beat or MAX_HOLD beats,
// then released for one idle (bubble) cycle before the next arbitration.
//   clk, reset_n              : clock, asynchronous active-low reset
//   req/last  [CHANNELS]      : per-channel beat valid / final-beat flag
//   in        [WIDTH*CHANNELS]: channel data
//   ready     [CHANNELS]      : per-channel beat accept (only ready[sel])
//   out_data/out_valid        : downstream beat, out_ready is its accept
//   sel/enable                : registered mux select and enable
//   busy                      : a grant is active
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter  int CHANNELS  = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_HOLD  = 16,
    localparam int ADDR_SIZE = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS-1:0]       last,
    input  logic [WIDTH*CHANNELS-1:0] in,
    output logic [CHANNELS-1:0]       ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_SIZE-1:0]      sel,
    output logic                      enable,
    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t           state_q,  state_d;
    logic [ADDR_SIZE-1:0] sel_q,    sel_d;
    logic [ADDR_SIZE-1:0] ptr_q,    ptr_d;
    logic                 enable_q, enable_d;
    logic                 busy_q,   busy_d;
    logic [CNT_W-1:0]     count_q,  count_d;

    logic [ADDR_SIZE-1:0] winner_s;
    logic                 any_s;
    logic                 req_sel_s;
    logic                 last_sel_s;
    logic                 xfer_s;
    logic                 release_s;
    logic [CHANNELS-1:0]  onehot_s;

    rr_pick #(
        .CHANNELS  (CHANNELS),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner_s),
        .any    (any_s)
    );

    mux #(
        .CHANNELS  (CHANNELS),
        .WIDTH     (WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mux (
        .sel    (sel_q),
        .enable (enable_q),
        .in     (in),
        .out    (out_data)
    );

    decoder #(
        .CHANNELS  (CHANNELS),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_decoder (
        .sel    (sel_q),
        .enable (enable_q),
        .onehot (onehot_s)
    );

    // Owner's handshake view and beat transfer/release qualification.
    always_comb begin
        req_sel_s  = req[sel_q];
        last_sel_s = last[sel_q];
        xfer_s     = (state_q == GRANT) && req_sel_s && out_ready;
        // The MAX_HOLD-th beat is the one seen while count holds MAX_HOLD-1.
        release_s  = xfer_s && (last_sel_s || (count_q == CNT_W'(MAX_HOLD - 1)));
    end

    // Downstream and requester-side handshake outputs.
    always_comb begin
        out_valid = enable_q && req_sel_s;
        ready     = onehot_s & {CHANNELS{out_ready}};
    end

    // Next-state logic for the arbitration FSM.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        enable_d = enable_q;
        busy_d   = busy_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    sel_d    = winner_s;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = GRANT;
                end else begin
                    state_d  = IDLE;
                end
            end
            GRANT: begin
                if (release_s) begin
                    // Released owner becomes lowest priority; sel is left as is.
                    ptr_d    = sel_q;
                    count_d  = {CNT_W{1'b0}};
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (xfer_s) begin
                    count_d  = count_q + CNT_W'(1);
                end else begin
                    // Stalled or owner idle mid-packet: hold everything.
                    count_d  = count_q;
                end
            end
            default: begin
                enable_d = 1'b0;
                busy_d   = 1'b0;
                count_d  = {CNT_W{1'b0}};
                state_d  = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sel_q    <= {ADDR_SIZE{1'b0}};
            ptr_q    <= ADDR_SIZE'(CHANNELS - 1);
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

    assign sel    = sel_q;
    assign enable = enable_q;
    assign busy   = busy_q;

endmodule
